// File: rtl/router_pkg.sv
// Shared definitions for the 4-output simple router and the blocks that feed it.
package router_pkg;

    localparam int ROUTER_PORTS  = 4;
    localparam int ROUTER_ADDR_W = 2;

    typedef logic [ROUTER_ADDR_W-1:0] router_addr_t;

endpackage : router_pkg

// File: rtl/router_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of `eligible` at or after `ptr`,
// found by rotating a doubled copy of the vector and priority-encoding the result.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] winner,
    output logic          any_grant
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [PW-1:0]  offset;
    logic [PW:0]    sum;

    // NOTE: every signal written here gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        doubled   = {eligible, eligible};
        rotated   = N'(doubled >> ptr);
        offset    = '0;
        any_grant = 1'b0;
        // Descending scan so the lowest offset (closest to ptr) is left standing.
        for (int j = N - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                offset    = PW'(j);
                any_grant = 1'b1;
            end
        end

        // Explicit modulo so non-power-of-2 N wraps correctly.
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
        end
        winner = sum[PW-1:0];

        grant = '0;
        if (any_grant) begin
            grant[winner] = 1'b1;
        end
    end

endmodule : rr_pick

// File: rtl/router_rr_sched.sv
// Round-robin scheduler sharing the router's single input among NUM_REQ requesters;
// holds the priority pointer, the registered router-side outputs and a transfer count.
module router_rr_sched
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              enable,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ*ROUTER_ADDR_W-1:0]  req_addr,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [ROUTER_PORTS-1:0]           dest_ready,
    output logic [DATA_WIDTH-1:0]             din,
    output logic                              din_en,
    output router_addr_t                      addr,
    output logic [CNT_WIDTH-1:0]              xfer_cnt
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]         ptr;
    logic [PW-1:0]         winner;
    logic [PW-1:0]         next_ptr;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic                  any_grant;
    logic [DATA_WIDTH-1:0] data_lane [NUM_REQ];
    router_addr_t          addr_lane [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_lane[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            addr_lane[i] = req_addr[i*ROUTER_ADDR_W +: ROUTER_ADDR_W];
            // A blocked destination only removes this requester, never the others.
            eligible[i]  = enable & req_valid[i] & dest_ready[addr_lane[i]];
        end
    end

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .eligible  (eligible),
        .ptr       (ptr),
        .grant     (grant),
        .winner    (winner),
        .any_grant (any_grant)
    );

    // Grant is masked by reset so nothing is offered while the block is held.
    assign req_ready = grant & {NUM_REQ{resetn}};
    assign next_ptr  = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr      <= '0;
            din      <= '0;
            din_en   <= 1'b0;
            addr     <= '0;
            xfer_cnt <= '0;
        end else if (any_grant) begin
            din      <= data_lane[winner];
            addr     <= addr_lane[winner];
            din_en   <= 1'b1;
            ptr      <= next_ptr;
            xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
        end else begin
            // Idle cycles present zeros, matching the router's own idle outputs.
            din      <= '0;
            din_en   <= 1'b0;
            addr     <= '0;
        end
    end

endmodule : router_rr_sched

// File: tb/tb_router_rr_sched.sv
// Directed bench for router_rr_sched: a vector table for per-cycle arbitration
// plus hand sequences for reset, latency and counter wrap.
module tb_router_rr_sched;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int CW = 4;

    logic            clk;
    logic            resetn;
    logic            enable;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR*2-1:0] req_addr;
    logic [NR-1:0]   req_ready;
    logic [3:0]      dest_ready;
    logic [DW-1:0]   din;
    logic            din_en;
    logic [1:0]      addr;
    logic [CW-1:0]   xfer_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    router_rr_sched #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .dest_ready (dest_ready),
        .din        (din),
        .din_en     (din_en),
        .addr       (addr),
        .xfer_cnt   (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] valid;
        logic [7:0] raddr;
        logic [3:0] dest;
        logic [3:0] exp_ready;
        logic       exp_en;
        logic [1:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [DW-1:0] lane_data(input int i);
        return 32'hC0DE_0000 | DW'(i * 16'h1111 + 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [CW-1:0] cnt_model;
        logic [DW-1:0] exp_din;
        int            idx;

        // ptr evolves 0->1->2->3->0->1 | 0 | 2 | 3 | 0 | 2 | idle, enable off | 3 | ...
        vecs.push_back('{1'b1, 4'hF,    8'hE4, 4'hF,    4'b0001, 1'b1, 2'd0}); // rotation
        vecs.push_back('{1'b1, 4'hF,    8'hE4, 4'hF,    4'b0010, 1'b1, 2'd1});
        vecs.push_back('{1'b1, 4'hF,    8'hE4, 4'hF,    4'b0100, 1'b1, 2'd2});
        vecs.push_back('{1'b1, 4'hF,    8'hE4, 4'hF,    4'b1000, 1'b1, 2'd3});
        vecs.push_back('{1'b1, 4'hF,    8'hE4, 4'hF,    4'b0001, 1'b1, 2'd0});
        vecs.push_back('{1'b1, 4'b1000, 8'hE4, 4'hF,    4'b1000, 1'b1, 2'd3}); // ptr wraps to 0
        vecs.push_back('{1'b1, 4'b0011, 8'h0E, 4'b1011, 4'b0010, 1'b1, 2'd3}); // skip blocked req0
        vecs.push_back('{1'b1, 4'hF,    8'hE4, 4'hF,    4'b0100, 1'b1, 2'd2}); // ptr was 2
        vecs.push_back('{1'b1, 4'hF,    8'h55, 4'b0010, 4'b1000, 1'b1, 2'd1}); // same destination
        vecs.push_back('{1'b1, 4'b0010, 8'hE4, 4'hF,    4'b0010, 1'b1, 2'd1}); // ptr -> 2
        vecs.push_back('{1'b1, 4'h0,    8'hE4, 4'hF,    4'b0000, 1'b0, 2'd0}); // idle
        vecs.push_back('{1'b0, 4'hF,    8'hE4, 4'hF,    4'b0000, 1'b0, 2'd0}); // enable off
        vecs.push_back('{1'b0, 4'hF,    8'hE4, 4'hF,    4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 4'hF,    8'hE4, 4'hF,    4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 4'hF,    8'hE4, 4'hF,    4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 4'hF,    8'hE4, 4'hF,    4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b1, 4'hF,    8'hE4, 4'hF,    4'b0100, 1'b1, 2'd2}); // resumes at ptr 2
        vecs.push_back('{1'b0, 4'hF,    8'hE4, 4'hF,    4'b0000, 1'b0, 2'd0}); // enable drop
        vecs.push_back('{1'b1, 4'b0001, 8'h02, 4'hF,    4'b0001, 1'b1, 2'd2}); // back-to-back
        vecs.push_back('{1'b1, 4'b0001, 8'h02, 4'hF,    4'b0001, 1'b1, 2'd2});
        vecs.push_back('{1'b1, 4'b0001, 8'h02, 4'hF,    4'b0001, 1'b1, 2'd2});
        vecs.push_back('{1'b1, 4'b0001, 8'h02, 4'b1011, 4'b0000, 1'b0, 2'd0}); // only dest blocked

        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = lane_data(i);
        resetn     = 1'b0;
        enable     = 1'b1;
        req_valid  = 4'hF;
        req_addr   = 8'hE4;
        dest_ready = 4'hF;

        #3;
        check("reset req_ready", 32'(req_ready), 32'h0);
        check("reset din_en",    32'(din_en),    32'h0);
        check("reset din",       din,            32'h0);
        check("reset addr",      32'(addr),      32'h0);
        check("reset xfer_cnt",  32'(xfer_cnt),  32'h0);
        req_valid = '0;
        @(negedge clk);
        resetn = 1'b1;

        cnt_model = '0;
        foreach (vecs[i]) begin
            @(negedge clk);
            enable     = vecs[i].en;
            req_valid  = vecs[i].valid;
            req_addr   = vecs[i].raddr;
            dest_ready = vecs[i].dest;
            #1;
            check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            idx = 0;
            for (int k = 0; k < NR; k++) if (vecs[i].exp_ready[k]) idx = k;
            exp_din = vecs[i].exp_en ? lane_data(idx) : '0;
            if (vecs[i].exp_en) cnt_model = cnt_model + CW'(1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d din_en", i),   32'(din_en),   32'(vecs[i].exp_en));
            check($sformatf("v%0d addr", i),     32'(addr),     32'(vecs[i].exp_addr));
            check($sformatf("v%0d din", i),      din,           exp_din);
            check($sformatf("v%0d xfer_cnt", i), 32'(xfer_cnt), 32'(cnt_model));
        end

        // Data/latency: req2 with a distinctive word, then an empty cycle.
        @(negedge clk);
        req_data[2*DW +: DW] = 32'hDEAD_BEEF;
        enable     = 1'b1;
        req_valid  = 4'b0100;
        req_addr   = 8'h10;
        dest_ready = 4'hF;
        #1;
        check("lat req_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        check("lat din",    din,          32'hDEAD_BEEF);
        check("lat addr",   32'(addr),    32'h1);
        check("lat din_en", 32'(din_en),  32'h1);
        @(negedge clk);
        req_valid = '0;
        @(posedge clk);
        #1;
        check("lat idle din_en", 32'(din_en), 32'h0);
        check("lat idle din",    din,         32'h0);
        req_data[2*DW +: DW] = lane_data(2);

        // Asynchronous reset with a registered transfer in flight (ptr left at 2).
        @(negedge clk);
        req_valid = 4'b0010;
        req_addr  = 8'hE4;
        @(posedge clk);
        #1;
        check("pre-reset din_en", 32'(din_en), 32'h1);
        #1;
        resetn = 1'b0;
        #1;
        check("async din_en",    32'(din_en),    32'h0);
        check("async din",       din,            32'h0);
        check("async addr",      32'(addr),      32'h0);
        check("async xfer_cnt",  32'(xfer_cnt),  32'h0);
        check("async req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        resetn    = 1'b1;
        req_valid = 4'hF;
        #1;
        check("post-reset ptr grant", 32'(req_ready), 32'h1);

        // Counter wrap: 17 acceptances on a 4-bit counter.
        req_valid = 4'b0001;
        req_addr  = 8'h02;
        repeat (17) @(posedge clk);
        #1;
        check("cnt wrap", 32'(xfer_cnt), 32'h1);
        check("cnt wrap din_en", 32'(din_en), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_router_rr_sched
